// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the data-memory port
// seen by dmem_access_ctrl (slave) and by the pipeline/memory side (master).
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 10
);

   logic              REQ_READ;
   logic              REQ_WRITE;
   logic [2:0]        FUNCT3;
   logic [31:0]       REQ_ADDR;
   logic [31:0]       REQ_WDATA;
   logic [31:0]       LOAD_DATA;
   logic              READY;
   logic              BUSY;
   logic              ERR;
   logic              MEM_WE;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [31:0]       MEM_WDATA;
   logic [31:0]       MEM_RDATA;

   modport slave (
      input  REQ_READ, REQ_WRITE, FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RDATA,
      output LOAD_DATA, READY, BUSY, ERR, MEM_WE, MEM_ADDR, MEM_WDATA
   );

   modport master (
      output REQ_READ, REQ_WRITE, FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RDATA,
      input  LOAD_DATA, READY, BUSY, ERR, MEM_WE, MEM_ADDR, MEM_WDATA
   );

endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: RV32 loads/stores onto a word-wide memory, sub-word stores by read-modify-write.
// Build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise ERR instead of being silently aligned.
module dmem_access_ctrl #(
   parameter int ADDR_W = 10
) (
   input logic CLK,
   input logic RESET,
   dmem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, WR, RMW_RD, RMW_WR, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] idx_q;
   logic [1:0]        off_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q;
   logic [31:0]       load_q;
   logic              err_q;

   logic              req;
   logic              f3_ok;
   logic              misaligned;
   logic              req_bad;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       lane_ext;
   logic [31:0]       merged;

   // Classify the incoming request; a store takes priority over a simultaneous load.
   always_comb begin
      req        = bus.REQ_READ | bus.REQ_WRITE;
      f3_ok      = 1'b0;
      misaligned = 1'b0;
      if (bus.REQ_WRITE)
         f3_ok = !bus.FUNCT3[2] && (bus.FUNCT3[1:0] != 2'b11);
      else
         f3_ok = (bus.FUNCT3[1:0] != 2'b11) && !(bus.FUNCT3[2] && bus.FUNCT3[1]);
`ifdef DMEM_MISALIGN_TRAP_EN
      misaligned = ((bus.FUNCT3[1:0] == 2'b01) && bus.REQ_ADDR[0]) ||
                   ((bus.FUNCT3[1:0] == 2'b10) && (bus.REQ_ADDR[1:0] != 2'b00));
`endif
      req_bad = !f3_ok || misaligned;
   end

   always_comb begin
      rd_byte = bus.MEM_RDATA[7:0];
      case (off_q)
         2'd1:    rd_byte = bus.MEM_RDATA[15:8];
         2'd2:    rd_byte = bus.MEM_RDATA[23:16];
         2'd3:    rd_byte = bus.MEM_RDATA[31:24];
         default: rd_byte = bus.MEM_RDATA[7:0];
      endcase
      rd_half = off_q[1] ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0];
      case (f3_q)
         3'b000:  lane_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  lane_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  lane_ext = {24'b0, rd_byte};
         3'b101:  lane_ext = {16'b0, rd_half};
         default: lane_ext = bus.MEM_RDATA;
      endcase
   end

   // Only SB/SH reach the merge, so f3_q[0] alone separates half from byte.
   always_comb begin
      merged = merge_q;
      if (f3_q[0]) begin
         if (off_q[1])
            merged[31:16] = wdata_q[15:0];
         else
            merged[15:0] = wdata_q[15:0];
      end else begin
         case (off_q)
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.BUSY      = 1'b1;
      bus.READY     = 1'b0;
      bus.MEM_WE    = 1'b0;
      bus.MEM_WDATA = 32'b0;
      case (state)
         IDLE: begin
            bus.BUSY = req;
            if (req) begin
               if (req_bad)
                  state_nxt = DONE;
               else if (bus.REQ_WRITE)
                  state_nxt = (bus.FUNCT3[1:0] == 2'b10) ? WR : RMW_RD;
               else
                  state_nxt = LOAD;
            end
         end
         LOAD:   state_nxt = DONE;
         WR: begin
            bus.MEM_WE    = 1'b1;
            bus.MEM_WDATA = wdata_q;
            state_nxt     = DONE;
         end
         RMW_RD: state_nxt = RMW_WR;
         RMW_WR: begin
            bus.MEM_WE    = 1'b1;
            bus.MEM_WDATA = merged;
            state_nxt     = DONE;
         end
         DONE: begin
            bus.BUSY  = 1'b0;
            bus.READY = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.MEM_ADDR  = idx_q;
   assign bus.LOAD_DATA = load_q;
   assign bus.ERR       = (state == DONE) && err_q;

   // Reset clears the address latch too, so an abandoned access leaves MEM_ADDR at 0.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         f3_q    <= 3'b0;
         idx_q   <= '0;
         off_q   <= 2'b0;
         wdata_q <= 32'b0;
         merge_q <= 32'b0;
         load_q  <= 32'b0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req) begin
            f3_q    <= bus.FUNCT3;
            idx_q   <= bus.REQ_ADDR[ADDR_W+1:2];
            off_q   <= bus.REQ_ADDR[1:0];
            wdata_q <= bus.REQ_WDATA;
            err_q   <= req_bad;
         end
         if (state == LOAD)
            load_q <= lane_ext;
         if (state == RMW_RD)
            merge_q <= bus.MEM_RDATA;
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by random
// loads/stores compared against a byte-array model of memory.
module tb_dmem_access_ctrl;

   localparam int ADDR_W = 10;

   logic        CLK = 1'b0;
   logic        RESET;
   int          total = 0;
   int          bad = 0;
   logic [31:0] mem [1024];
   logic [7:0]  ref_bytes [4096];
   logic [31:0] ld_exp;
   logic [31:0] last_we_addr;
   logic [31:0] last_we_data;

   dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   assign bus.MEM_RDATA = mem[bus.MEM_ADDR];

   always @(posedge CLK) begin
      if (bus.MEM_WE)
         mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
   end

   function automatic logic [31:0] refWord(input int w);
      return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: memory is a flat byte array; loads/stores act on whole byte lanes.
   task automatic modelOp(input logic is_store, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err, output int we_cnt);
      int          size;
      int          a;
      logic        ok;
      logic        mis;
      logic [31:0] val;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (is_store)
         ok = (f3 inside {3'b000, 3'b001, 3'b010});
      else
         ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      a = int'(addr[11:0]);
      mis = (a % size) != 0;
`ifndef DMEM_MISALIGN_TRAP_EN
      mis = 1'b0;
`endif
      if (!ok || mis) begin
         lat = 1;
         err = 1'b1;
         we_cnt = 0;
         return;
      end
      a = a - (a % size);
      err = 1'b0;
      if (is_store) begin
         for (int i = 0; i < size; i++)
            ref_bytes[a+i] = wdata[8*i +: 8];
         lat = (size == 4) ? 2 : 3;
         we_cnt = 1;
      end else begin
         val = 32'b0;
         for (int i = 0; i < size; i++)
            val[8*i +: 8] = ref_bytes[a+i];
         if (!f3[2] && size == 1)
            val = {{24{val[7]}}, val[7:0]};
         else if (!f3[2] && size == 2)
            val = {{16{val[15]}}, val[15:0]};
         ld_exp = val;
         lat = 2;
         we_cnt = 0;
      end
   endtask

   task automatic applyStimulus(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
      int   exp_lat;
      int   exp_we;
      int   n;
      int   we_seen;
      logic exp_err;
      logic got_ready;
      modelOp(wr, f3, addr, wdata, exp_lat, exp_err, exp_we);
      @(negedge CLK);
      bus.REQ_READ  = rd;
      bus.REQ_WRITE = wr;
      bus.FUNCT3    = f3;
      bus.REQ_ADDR  = addr;
      bus.REQ_WDATA = wdata;
      n = 0;
      we_seen = 0;
      got_ready = 1'b0;
      while (!got_ready && n < 10) begin
         @(posedge CLK);
         #1;
         n++;
         if (bus.MEM_WE) begin
            we_seen++;
            last_we_addr = 32'(bus.MEM_ADDR);
            last_we_data = bus.MEM_WDATA;
         end
         if (bus.READY)
            got_ready = 1'b1;
      end
      checkOutput({tag, ":latency"}, n, exp_lat);
      checkOutput({tag, ":err"}, 32'(bus.ERR), 32'(exp_err));
      checkOutput({tag, ":we_pulses"}, we_seen, exp_we);
      checkOutput({tag, ":load_data"}, bus.LOAD_DATA, ld_exp);
      checkOutput({tag, ":busy_in_done"}, 32'(bus.BUSY), 32'd0);
      bus.REQ_READ  = 1'b0;
      bus.REQ_WRITE = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput({tag, ":ready_pulse"}, 32'(bus.READY), 32'd0);
      checkOutput({tag, ":mem_word"}, mem[addr[11:2]], refWord(int'(addr[11:2])));
   endtask

   initial begin
      logic [2:0]  r_f3;
      logic        r_wr;
      logic        r_rd;
      logic [31:0] r_addr;
      RESET         = 1'b1;
      bus.REQ_READ  = 1'b0;
      bus.REQ_WRITE = 1'b0;
      bus.FUNCT3    = 3'b0;
      bus.REQ_ADDR  = 32'b0;
      bus.REQ_WDATA = 32'b0;
      ld_exp        = 32'b0;
      last_we_addr  = 32'b0;
      last_we_data  = 32'b0;
      for (int i = 0; i < 1024; i++)
         mem[i] = 32'b0;
      for (int i = 0; i < 4096; i++)
         ref_bytes[i] = 8'b0;
      mem[1]       = 32'h0000_0056;
      ref_bytes[4] = 8'h56;

      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset:ready", 32'(bus.READY), 32'd0);
      checkOutput("reset:busy", 32'(bus.BUSY), 32'd0);
      checkOutput("reset:err", 32'(bus.ERR), 32'd0);
      checkOutput("reset:mem_we", 32'(bus.MEM_WE), 32'd0);
      checkOutput("reset:mem_addr", 32'(bus.MEM_ADDR), 32'd0);
      checkOutput("reset:load_data", bus.LOAD_DATA, 32'd0);
      RESET = 1'b0;

      applyStimulus("lb_0x4", 1'b1, 1'b0, 3'b000, 32'h4, 32'h0);
      checkOutput("lb_0x4:value", bus.LOAD_DATA, 32'h0000_0056);

      applyStimulus("sb_0x5", 1'b0, 1'b1, 3'b000, 32'h5, 32'h0000_00AB);
      checkOutput("sb_0x5:we_addr", last_we_addr, 32'd1);
      checkOutput("sb_0x5:we_data", last_we_data, 32'h0000_AB56);
      applyStimulus("lw_0x4", 1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
      checkOutput("lw_0x4:value", bus.LOAD_DATA, 32'h0000_AB56);

      applyStimulus("sh_0x8", 1'b0, 1'b1, 3'b001, 32'h8, 32'h0000_8001);
      applyStimulus("lh_0x8", 1'b1, 1'b0, 3'b001, 32'h8, 32'h0);
      checkOutput("lh_0x8:value", bus.LOAD_DATA, 32'hFFFF_8001);
      applyStimulus("lhu_0x8", 1'b1, 1'b0, 3'b101, 32'h8, 32'h0);
      checkOutput("lhu_0x8:value", bus.LOAD_DATA, 32'h0000_8001);
      applyStimulus("lbu_0x9", 1'b1, 1'b0, 3'b100, 32'h9, 32'h0);
      checkOutput("lbu_0x9:value", bus.LOAD_DATA, 32'h0000_0080);
      applyStimulus("lb_0x9", 1'b1, 1'b0, 3'b000, 32'h9, 32'h0);
      checkOutput("lb_0x9:value", bus.LOAD_DATA, 32'hFFFF_FF80);

      applyStimulus("sw_rd_wr_0xc", 1'b1, 1'b1, 3'b010, 32'hC, 32'hDEAD_BEEF);
      checkOutput("sw_rd_wr_0xc:word3", mem[3], 32'hDEAD_BEEF);
      checkOutput("sw_rd_wr_0xc:load_kept", bus.LOAD_DATA, 32'hFFFF_FF80);

      // Abandon an SB while it is in its read phase.
      @(negedge CLK);
      bus.REQ_WRITE = 1'b1;
      bus.REQ_READ  = 1'b0;
      bus.FUNCT3    = 3'b000;
      bus.REQ_ADDR  = 32'h4;
      bus.REQ_WDATA = 32'h0000_00FF;
      @(posedge CLK);
      #1;
      checkOutput("rst_mid:busy_before", 32'(bus.BUSY), 32'd1);
      RESET = 1'b1;
      bus.REQ_WRITE = 1'b0;
      @(posedge CLK);
      #1;
      ld_exp = 32'b0;
      checkOutput("rst_mid:ready", 32'(bus.READY), 32'd0);
      checkOutput("rst_mid:busy", 32'(bus.BUSY), 32'd0);
      checkOutput("rst_mid:err", 32'(bus.ERR), 32'd0);
      checkOutput("rst_mid:mem_we", 32'(bus.MEM_WE), 32'd0);
      checkOutput("rst_mid:mem_addr", 32'(bus.MEM_ADDR), 32'd0);
      checkOutput("rst_mid:mem_wdata", bus.MEM_WDATA, 32'd0);
      checkOutput("rst_mid:load_data", bus.LOAD_DATA, 32'd0);
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("rst_mid:mem_we_after", 32'(bus.MEM_WE), 32'd0);
      checkOutput("rst_mid:word1", mem[1], 32'h0000_AB56);

      applyStimulus("lw_0x6", 1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
      checkOutput("lw_0x6:trap_load_kept", bus.LOAD_DATA, 32'd0);
`else
      checkOutput("lw_0x6:aligned_value", bus.LOAD_DATA, 32'h0000_AB56);
`endif
      applyStimulus("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
      applyStimulus("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h10, 32'h1234_5678);
      checkOutput("st_f3_011:word4", mem[4], 32'd0);
      applyStimulus("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h14, 32'h1234_5678);

      for (int k = 0; k < 80; k++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_rd   = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         applyStimulus($sformatf("rand%0d", k), r_rd, r_wr, r_f3, r_addr, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
